// File: rtl/rf_hazard_ctl.sv
// rf_hazard_ctl
// Scoreboard and issue controller for the decode stage.
// Each architectural register has a small counter of writes that have issued
// but not yet been written back. Decode is stalled while a source register
// has a write in flight (RAW hazard), or while the destination counter is
// saturated. A halt instruction starts a drain: nothing else issues, and the
// core reports halted once every counter has returned to zero.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   id_valid   decode holds a valid instruction
//   rs_addr    first source register;  rs_used: instruction reads rs
//   rt_addr    second source register; rt_used: instruction reads rt
//   rd_addr    destination register;   rd_wr: instruction writes rd
//   ex_ready   execute can accept an instruction
//   wb_valid   one pending write retires into wb_addr this cycle
//   wb_addr    register being written back
//   flush      squash everything in flight
//   halt_req   decode holds a halt/dump instruction (level)
//   issue      instruction accepted into execute this cycle
//   stall      decode must hold its instruction
//   pending    bit i set when register i has a write in flight
//   halted     drain complete, core quiescent
//   error      sticky: writeback arrived for a register with nothing pending
//   state_dbg  FSM state: 0 = RUN, 1 = DRAIN, 2 = HALTED
//
// Handshake: decode presents an instruction with id_valid and execute
// signals capacity with ex_ready. An instruction transfers in exactly the
// cycles where issue=1. While id_valid=1 and issue=0, stall=1 and decode must
// keep its instruction stable. issue and stall are combinational and add no
// latency.
module rf_hazard_ctl #(
  parameter int NREG   = 8,
  parameter int AW     = 3,
  parameter int CNT_W  = 2,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [AW-1:0]   rs_addr,
  input  logic            rs_used,
  input  logic [AW-1:0]   rt_addr,
  input  logic            rt_used,
  input  logic [AW-1:0]   rd_addr,
  input  logic            rd_wr,
  input  logic            ex_ready,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic            flush,
  input  logic            halt_req,
  output logic            issue,
  output logic            stall,
  output logic [NREG-1:0] pending,
  output logic            halted,
  output logic            error,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];

  logic hazard_s, hazard_t, full;
  logic issue_run;
  logic underflow;
  logic all_zero_nxt;

  // Hazard detection. With BYPASS, a writeback landing this cycle on the
  // last in-flight write of a source is forwarded by the register file, so
  // the reader need not wait for it.
  always_comb begin
    hazard_s = rs_used && (cnt[rs_addr] != '0) &&
               !((BYPASS != 0) && wb_valid && (wb_addr == rs_addr) &&
                 (cnt[rs_addr] == CNT_ONE));
    hazard_t = rt_used && (cnt[rt_addr] != '0) &&
               !((BYPASS != 0) && wb_valid && (wb_addr == rt_addr) &&
                 (cnt[rt_addr] == CNT_ONE));
    // A saturated counter can still take a new write if one retires now.
    full     = rd_wr && (cnt[rd_addr] == CNT_MAX) &&
               !(wb_valid && (wb_addr == rd_addr));
    issue_run = id_valid && !halt_req && !hazard_s && !hazard_t && !full &&
                ex_ready && !flush;
  end

  // Issue/stall. Both are held low while reset is asserted.
  always_comb begin
    issue = 1'b0;
    stall = 1'b0;
    if (rst) begin
      issue = (state == ST_RUN) ? issue_run : 1'b0;
      stall = id_valid && !issue;
    end
  end

  // Counter next state. Flush wipes everything and ignores that cycle's
  // issue and writeback. A writeback with nothing pending is dropped and
  // flagged rather than wrapping the counter.
  always_comb begin
    underflow    = wb_valid && !flush && (cnt[wb_addr] == '0);
    all_zero_nxt = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      logic inc_i, dec_i;
      inc_i = issue && rd_wr && (rd_addr == AW'(i));
      dec_i = wb_valid && (wb_addr == AW'(i)) && (cnt[i] != '0);
      cnt_nxt[i] = cnt[i];
      if (flush) begin
        cnt_nxt[i] = '0;
      end else if (inc_i && !dec_i) begin
        cnt_nxt[i] = cnt[i] + CNT_ONE;
      end else if (dec_i && !inc_i) begin
        cnt_nxt[i] = cnt[i] - CNT_ONE;
      end
      if (cnt_nxt[i] != '0) all_zero_nxt = 1'b0;
    end
  end

  // FSM next state. The DRAIN exit looks at next-cycle counters so a final
  // writeback that empties them halts on the following edge.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (!flush && id_valid && halt_req) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (flush)             state_nxt = ST_RUN;
        else if (all_zero_nxt) state_nxt = ST_HALTED;
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
      error <= 1'b0;
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      state <= state_nxt;
      if (underflow) error <= 1'b1;
      for (int i = 0; i < NREG; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) pending[i] = (cnt[i] != '0);
    halted    = (state == ST_HALTED);
    state_dbg = state;
  end

endmodule

// File: tb/tb_rf_hazard_ctl.sv
module tb_rf_hazard_ctl;

  localparam int NREG = 8, AW = 3, CNT_W = 2, BYPASS = 1;
  localparam int CMAX = (1 << CNT_W) - 1;
  localparam int EW = 14;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            id_valid, rs_used, rt_used, rd_wr, ex_ready;
  logic            wb_valid, flush, halt_req;
  logic [AW-1:0]   rs_addr, rt_addr, rd_addr, wb_addr;
  logic            issue, stall, halted, error;
  logic [NREG-1:0] pending;
  logic [1:0]      state_dbg;

  int n_vec = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];

  // Reference model: plain integer counts per register plus a phase.
  int m_cnt[NREG];
  int m_phase;  // 0 running, 1 draining, 2 halted
  bit m_err;

  rf_hazard_ctl #(.NREG(NREG), .AW(AW), .CNT_W(CNT_W), .BYPASS(BYPASS)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .rs_addr(rs_addr), .rs_used(rs_used), .rt_addr(rt_addr), .rt_used(rt_used),
    .rd_addr(rd_addr), .rd_wr(rd_wr), .ex_ready(ex_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush), .halt_req(halt_req),
    .issue(issue), .stall(stall), .pending(pending), .halted(halted),
    .error(error), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic bit src_blocked(input bit used, input int a);
    return used && m_cnt[a] > 0 &&
           !(BYPASS != 0 && wb_valid && int'(wb_addr) == a && m_cnt[a] == 1);
  endfunction

  function automatic bit model_issue();
    bit full;
    full = rd_wr && m_cnt[rd_addr] == CMAX && !(wb_valid && wb_addr == rd_addr);
    return m_phase == 0 && id_valid && !halt_req && !flush && ex_ready && !full &&
           !src_blocked(rs_used, int'(rs_addr)) && !src_blocked(rt_used, int'(rt_addr));
  endfunction

  task automatic model_step(input bit did_issue);
    int wb_pre, total;
    if (flush) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      if (m_phase != 2) m_phase = 0;
    end else begin
      wb_pre = m_cnt[wb_addr];
      if (did_issue && rd_wr) m_cnt[rd_addr] = m_cnt[rd_addr] + 1;
      if (wb_valid) begin
        if (wb_pre == 0) m_err = 1'b1;
        else m_cnt[wb_addr] = m_cnt[wb_addr] - 1;
      end
      total = 0;
      foreach (m_cnt[i]) total += m_cnt[i];
      if (m_phase == 0 && id_valid && halt_req) m_phase = 1;
      else if (m_phase == 1 && total == 0) m_phase = 2;
    end
  endtask

  function automatic logic [NREG-1:0] model_pending();
    logic [NREG-1:0] p;
    foreach (m_cnt[i]) p[i] = (m_cnt[i] != 0);
    return p;
  endfunction

  // ---------------- drivers ----------------
  task automatic idle();
    id_valid = 0; rs_used = 0; rt_used = 0; rd_wr = 0; ex_ready = 1;
    wb_valid = 0; flush = 0; halt_req = 0;
    rs_addr = 0; rt_addr = 0; rd_addr = 0; wb_addr = 0;
  endtask

  // Called just after a falling edge with inputs already set.
  task automatic cycle();
    logic e_issue, e_stall;
    logic [EW-1:0] e;
    #1;
    e_issue = model_issue();
    e_stall = id_valid && !e_issue;
    exp_q.push_back({2'(m_phase), m_err, (m_phase == 2), model_pending(), e_stall, e_issue});
    e = exp_q.pop_front();
    check("issue",   issue,     e[0]);
    check("stall",   stall,     e[1]);
    check("pending", pending,   e[9:2]);
    check("halted",  halted,    e[10]);
    check("error",   error,     e[11]);
    check("state",   state_dbg, e[13:12]);
    @(posedge clk);
    model_step(e_issue);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    id_valid = 1; rd_wr = 1;
    rst = 0;
    #1;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_phase = 0; m_err = 0;
    check("rst_issue",   issue,     0);
    check("rst_stall",   stall,     0);
    check("rst_pending", pending,   0);
    check("rst_halted",  halted,    0);
    check("rst_error",   error,     0);
    check("rst_state",   state_dbg, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    idle();
  endtask

  task automatic write_reg(input int r);
    idle(); id_valid = 1; rd_addr = AW'(r); rd_wr = 1; cycle();
  endtask

  task automatic wb(input int r);
    idle(); wb_valid = 1; wb_addr = AW'(r); cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    @(negedge clk);
    do_reset();

    // 1: write r3, then a reader of r3 stalls until its writeback
    idle(); id_valid = 1; rd_addr = 3; rd_wr = 1; #1;
    check("t1_issue", issue, 1);
    cycle();
    check("t1_pending", pending, 8'h08);
    idle(); id_valid = 1; rs_addr = 3; rs_used = 1; cycle();
    #1; check("t1_stall", stall, 1);
    cycle();
    // 2: same-cycle writeback is bypassed
    wb_valid = 1; wb_addr = 3; #1;
    check("t2_bypass_issue", issue, 1);
    cycle();

    // 3: counter saturation on r5
    do_reset();
    repeat (3) write_reg(5);
    idle(); id_valid = 1; rd_addr = 5; rd_wr = 1; #1;
    check("t3_full_stall", stall, 1);
    cycle();
    wb_valid = 1; wb_addr = 5; #1;
    check("t3_full_wb_issue", issue, 1);
    cycle();
    idle(); cycle();

    // 4: flush with concurrent writeback
    do_reset();
    write_reg(2); write_reg(2);
    idle(); flush = 1; wb_valid = 1; wb_addr = 2; cycle();
    check("t4_pending", pending, 0);
    check("t4_error", error, 0);

    // 5: underflow is sticky
    wb(6);
    check("t5_error", error, 1);
    idle(); cycle();
    check("t5_error_hold", error, 1);
    check("t5_pending6", pending[6], 0);

    // 6: drain then halt
    do_reset();
    write_reg(0); write_reg(4);
    check("t6_pending", pending, 8'h11);
    idle(); id_valid = 1; halt_req = 1; cycle();
    wb(0);
    check("t6_not_halted", halted, 0);
    wb(4);
    check("t6_halted", halted, 1);
    idle(); id_valid = 1; rd_wr = 1; rd_addr = 1; cycle();
    // reset mid-drain
    do_reset();
    write_reg(1);
    idle(); id_valid = 1; halt_req = 1; cycle();
    do_reset();
    check("t6_rst_halted", halted, 0);

    // Random traffic on a narrow register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      if (m_phase == 2 || (m_phase == 1 && $urandom_range(0, 29) == 0)) do_reset();
      id_valid = ($urandom_range(0, 3) != 0);
      rs_addr  = AW'($urandom_range(0, 3)); rs_used = 1'($urandom_range(0, 1));
      rt_addr  = AW'($urandom_range(0, 3)); rt_used = 1'($urandom_range(0, 1));
      rd_addr  = AW'($urandom_range(0, 3)); rd_wr   = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 4) != 0);
      wb_valid = ($urandom_range(0, 2) == 0);
      wb_addr  = AW'($urandom_range(0, NREG - 1));
      if ($urandom_range(0, 19) != 0) begin
        for (int k = 0; k < NREG; k++) begin
          if (m_cnt[(int'(wb_addr) + k) % NREG] != 0) begin
            wb_addr = AW'((int'(wb_addr) + k) % NREG);
            break;
          end
        end
      end
      flush    = ($urandom_range(0, 24) == 0);
      halt_req = ($urandom_range(0, 39) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
